// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared state encoding, ID word and BR level helper for the Unibus interrupt arbiter
package irq_arb_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BRQ  = 3'd1,
        SACK = 3'd2,
        INTR = 3'd3,
        RELS = 3'd4
    } state_t;

    localparam logic [31:0] IRQ_ARB_ID = 32'h49410001;

    function automatic logic [3:0] br_bit(input logic [1:0] level);
        return 4'b0001 << level;
    endfunction
endpackage

// File: rtl/irq_prio_pick.sv
// irq_prio_pick: picks the eligible device with the highest BR level, lowest index on ties
module irq_prio_pick #(
    parameter int NDEV = 4,
    parameter logic [15:0] LEVELS = 16'h00FF
) (
    input  logic [NDEV-1:0] elig,
    output logic            any,
    output logic [2:0]      win,
    output logic [1:0]      lvl
);
    always_comb begin
        any = 1'b0;
        win = '0;
        lvl = '0;
        for (int i = 0; i < NDEV; i++) begin
            // strict compare keeps the earlier (lower) index on equal levels
            if (elig[i] && (!any || LEVELS[2*i+:2] > lvl)) begin
                any = 1'b1;
                win = 3'(i);
                lvl = LEVELS[2*i+:2];
            end
        end
    end
endmodule

// File: rtl/unibus_irq_arbiter.sv
// unibus_irq_arbiter: shares the Unibus BR/BG/SACK/INTR interrupt path among NDEV emulated devices
module unibus_irq_arbiter
    import irq_arb_pkg::*;
#(
    parameter int NDEV = 4,
    parameter logic [15:0] LEVELS = 16'h00FF,
    parameter int TIMEOUT = 1000000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              armwrite,
    input  logic              armraddr,
    input  logic              armwaddr,
    input  logic [31:0]       armwdata,
    output logic [31:0]       armrdata,
    input  logic [NDEV-1:0]   dev_intreq,
    input  logic [8*NDEV-1:0] dev_irvec,
    output logic [NDEV-1:0]   dev_intgnt,
    input  logic              init_in_h,
    input  logic [3:0]        bus_bg_in_h,
    input  logic              bus_ssyn_in_h,
    output logic [3:0]        bus_br_out_h,
    output logic              bus_sack_out_h,
    output logic              bus_intr_out_h,
    output logic [15:0]       bus_d_out_h
);
    state_t          state;
    logic [7:0]      mask;
    logic [7:0]      timeouts;
    logic [9:0]      grants;
    logic [2:0]      winner;
    logic [1:0]      level;
    logic [31:0]     timer;
    logic [NDEV-1:0] elig;
    logic            any;
    logic [2:0]      pick_win;
    logic [1:0]      pick_lvl;
    logic            win_req;
    logic            bg_hit;
    logic [7:0]      win_vec;
    logic            unused_ok;

    assign elig      = dev_intreq & mask[NDEV-1:0];
    assign win_req   = |(elig & (NDEV'(1) << winner));
    assign bg_hit    = |(bus_bg_in_h & br_bit(level));
    assign win_vec   = 8'(dev_irvec >> {winner, 3'b000});
    assign armrdata  = armraddr ? {state, winner, timeouts, grants, mask} : IRQ_ARB_ID;
    assign unused_ok = &{1'b0, armwdata[30:8]};

    irq_prio_pick #(.NDEV(NDEV), .LEVELS(LEVELS)) u_pick (
        .elig(elig),
        .any (any),
        .win (pick_win),
        .lvl (pick_lvl)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state          <= IDLE;
            mask           <= '0;
            timeouts       <= '0;
            grants         <= '0;
            winner         <= '0;
            level          <= '0;
            timer          <= '0;
            bus_br_out_h   <= '0;
            bus_sack_out_h <= 1'b0;
            bus_intr_out_h <= 1'b0;
            bus_d_out_h    <= '0;
            dev_intgnt     <= '0;
        end else begin
            dev_intgnt <= '0;
            if (init_in_h) begin
                state          <= IDLE;
                bus_br_out_h   <= '0;
                bus_sack_out_h <= 1'b0;
                bus_intr_out_h <= 1'b0;
                bus_d_out_h    <= '0;
            end else begin
                case (state)
                    IDLE: if (any) begin
                        winner       <= pick_win;
                        level        <= pick_lvl;
                        bus_br_out_h <= br_bit(pick_lvl);
                        timer        <= '0;
                        state        <= BRQ;
                    end
                    BRQ: if (bg_hit) begin
                        bus_br_out_h   <= '0;
                        bus_sack_out_h <= 1'b1;
                        state          <= SACK;
                    end else if (!win_req) begin
                        bus_br_out_h <= '0;
                        state        <= IDLE;
                    end else if (timer == 32'(TIMEOUT - 1)) begin
                        bus_br_out_h <= '0;
                        timeouts     <= (timeouts == '1) ? timeouts : timeouts + 8'd1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                    SACK: if (!bg_hit) begin
                        bus_intr_out_h <= 1'b1;
                        bus_d_out_h    <= {8'b0, win_vec};
                        dev_intgnt     <= NDEV'(1) << winner;
                        grants         <= (grants == '1) ? grants : grants + 10'd1;
                        state          <= INTR;
                    end
                    INTR: if (bus_ssyn_in_h) begin
                        bus_intr_out_h <= 1'b0;
                        bus_sack_out_h <= 1'b0;
                        bus_d_out_h    <= '0;
                        state          <= RELS;
                    end
                    RELS: if (!bus_ssyn_in_h) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (armwrite && armwaddr) begin
                mask <= armwdata[7:0];
                if (armwdata[31]) begin
                    grants   <= '0;
                    timeouts <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_unibus_irq_arbiter.sv
// tb_unibus_irq_arbiter: table-driven arbitration vectors plus hand-written bus sequences
module tb_unibus_irq_arbiter;
    localparam int NDEV = 4;
    // dev0=BR4, dev1=BR6, dev2=BR6, dev3=BR5
    localparam logic [15:0] LEVELS = 16'h0068;
    localparam int TIMEOUT = 100;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic        armraddr = 1'b1;
    logic        armwaddr = 1'b1;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic [3:0]  dev_intreq = '0;
    logic [31:0] dev_irvec = {8'h70, 8'h60, 8'o100, 8'h30};
    logic [3:0]  dev_intgnt;
    logic        init_in_h = 1'b0;
    logic [3:0]  bus_bg_in_h = '0;
    logic        bus_ssyn_in_h = 1'b0;
    logic [3:0]  bus_br_out_h;
    logic        bus_sack_out_h;
    logic        bus_intr_out_h;
    logic [15:0] bus_d_out_h;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] mask;
        logic [3:0] br;
        logic [2:0] win;
    } vec_t;
    vec_t tbl[9];

    unibus_irq_arbiter #(.NDEV(NDEV), .LEVELS(LEVELS), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .armwrite      (armwrite),
        .armraddr      (armraddr),
        .armwaddr      (armwaddr),
        .armwdata      (armwdata),
        .armrdata      (armrdata),
        .dev_intreq    (dev_intreq),
        .dev_irvec     (dev_irvec),
        .dev_intgnt    (dev_intgnt),
        .init_in_h     (init_in_h),
        .bus_bg_in_h   (bus_bg_in_h),
        .bus_ssyn_in_h (bus_ssyn_in_h),
        .bus_br_out_h  (bus_br_out_h),
        .bus_sack_out_h(bus_sack_out_h),
        .bus_intr_out_h(bus_intr_out_h),
        .bus_d_out_h   (bus_d_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic arm_mask(input logic [31:0] data);
        armwrite = 1'b1;
        armwdata = data;
        tick();
        armwrite = 1'b0;
    endtask

    // bus side of one full grant for a device already in BRQ at BR level lvl
    task automatic serve(input int lvl, input int dev);
        logic [7:0] v;
        v = 8'(dev_irvec >> (8 * dev));
        bus_bg_in_h = 4'(1 << lvl);
        tick();
        chk("sack_state", {29'd0, armrdata[31:29]}, 32'd2);
        chk("sack_on", {31'd0, bus_sack_out_h}, 32'd1);
        chk("br_off_at_bg", {28'd0, bus_br_out_h}, 32'd0);
        bus_bg_in_h = '0;
        tick();
        chk("intr_on", {31'd0, bus_intr_out_h}, 32'd1);
        chk("vector", {16'd0, bus_d_out_h}, {24'd0, v});
        chk("grant_pulse", {28'd0, dev_intgnt}, 32'(1 << dev));
        dev_intreq[dev] = 1'b0;
        tick();
        chk("grant_one_cycle", {28'd0, dev_intgnt}, 32'd0);
        chk("intr_held", {31'd0, bus_intr_out_h}, 32'd1);
        chk("vector_held", {16'd0, bus_d_out_h}, {24'd0, v});
        bus_ssyn_in_h = 1'b1;
        tick();
        chk("ssyn_drop", {15'd0, bus_intr_out_h, bus_sack_out_h, bus_d_out_h}, 32'd0);
        chk("rels_state", {29'd0, armrdata[31:29]}, 32'd4);
        bus_ssyn_in_h = 1'b0;
        tick();
        chk("back_idle", {29'd0, armrdata[31:29]}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{4'b0010, 8'h0F, 4'b0100, 3'd1};
        tbl[1] = '{4'b0101, 8'h0F, 4'b0100, 3'd2};
        tbl[2] = '{4'b0110, 8'h0F, 4'b0100, 3'd1};
        tbl[3] = '{4'b1001, 8'h0F, 4'b0010, 3'd3};
        tbl[4] = '{4'b1000, 8'h07, 4'b0000, 3'd0};
        tbl[5] = '{4'b1111, 8'h09, 4'b0010, 3'd3};
        tbl[6] = '{4'b0001, 8'h01, 4'b0001, 3'd0};
        tbl[7] = '{4'b1111, 8'h00, 4'b0000, 3'd0};
        tbl[8] = '{4'b0111, 8'h05, 4'b0100, 3'd2};

        tick();
        tick();
        RESET = 1'b0;
        chk("reset_reg1", armrdata, 32'd0);
        chk("reset_bus", {11'd0, dev_intgnt, bus_br_out_h, bus_sack_out_h, bus_intr_out_h, bus_d_out_h}, 32'd0);
        armraddr = 1'b0;
        #1;
        chk("id_reg0", armrdata, 32'h49410001);
        armraddr = 1'b1;

        // arbitration table; dropping the request in BRQ must abort without a grant
        for (int i = 0; i < 9; i++) begin
            arm_mask({24'd0, tbl[i].mask});
            dev_intreq = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_br", i), {28'd0, bus_br_out_h}, {28'd0, tbl[i].br});
            chk($sformatf("tbl%0d_state", i), {29'd0, armrdata[31:29]}, (tbl[i].br != 0) ? 32'd1 : 32'd0);
            if (tbl[i].br != 0) chk($sformatf("tbl%0d_win", i), {29'd0, armrdata[28:26]}, {29'd0, tbl[i].win});
            dev_intreq = '0;
            tick();
            chk($sformatf("tbl%0d_drop", i), {24'd0, dev_intgnt, bus_br_out_h}, 32'd0);
            chk($sformatf("tbl%0d_idle", i), {29'd0, armrdata[31:29]}, 32'd0);
        end
        chk("no_grants_after_aborts", {22'd0, armrdata[17:8]}, 32'd0);

        // full transaction for dev1 at BR6
        arm_mask(32'h0000000F);
        dev_intreq = 4'b0010;
        tick();
        chk("seq1_br6", {28'd0, bus_br_out_h}, 32'h4);
        serve(2, 1);
        chk("seq1_grants", {22'd0, armrdata[17:8]}, 32'd1);

        // dev0 (BR4) and dev2 (BR6) together: dev2 first, then dev0
        dev_intreq = 4'b0101;
        tick();
        chk("seq2_br_first", {28'd0, bus_br_out_h}, 32'h4);
        chk("seq2_win_first", {29'd0, armrdata[28:26]}, 32'd2);
        serve(2, 2);
        tick();
        chk("seq2_br_second", {28'd0, bus_br_out_h}, 32'h1);
        chk("seq2_win_second", {29'd0, armrdata[28:26]}, 32'd0);
        serve(0, 0);
        chk("seq2_grants", {22'd0, armrdata[17:8]}, 32'd3);

        // masked dev3 gets no BR until the mask is opened
        arm_mask(32'h00000007);
        dev_intreq = 4'b1000;
        tick();
        chk("seq3_masked", {28'd0, bus_br_out_h}, 32'd0);
        arm_mask(32'h0000000F);
        chk("seq3_write_cycle", {28'd0, bus_br_out_h}, 32'd0);
        tick();
        chk("seq3_br5", {28'd0, bus_br_out_h}, 32'h2);
        dev_intreq = '0;
        tick();

        // BG never arrives: BR held TIMEOUT cycles then abandoned
        dev_intreq = 4'b0001;
        tick();
        chk("seq4_br4", {28'd0, bus_br_out_h}, 32'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("seq4_still_br", {28'd0, bus_br_out_h}, 32'h1);
        tick();
        dev_intreq = '0;
        chk("seq4_timeout_br", {28'd0, bus_br_out_h}, 32'd0);
        chk("seq4_timeouts", {24'd0, armrdata[25:18]}, 32'd1);
        chk("seq4_idle", {29'd0, armrdata[31:29]}, 32'd0);
        chk("seq4_no_grant", {22'd0, armrdata[17:8]}, 32'd3);
        tick();

        // INIT during INTR clears the bus side but keeps mask and counters
        dev_intreq = 4'b0010;
        tick();
        bus_bg_in_h = 4'b0100;
        tick();
        bus_bg_in_h = '0;
        tick();
        chk("seq5_in_intr", {29'd0, armrdata[31:29]}, 32'd3);
        init_in_h = 1'b1;
        dev_intreq = '0;
        tick();
        init_in_h = 1'b0;
        chk("seq5_bus_clear", {11'd0, dev_intgnt, bus_br_out_h, bus_sack_out_h, bus_intr_out_h, bus_d_out_h}, 32'd0);
        chk("seq5_idle", {29'd0, armrdata[31:29]}, 32'd0);
        chk("seq5_mask_kept", {24'd0, armrdata[7:0]}, 32'h0F);
        chk("seq5_grants_kept", {22'd0, armrdata[17:8]}, 32'd4);

        // bit 31 clears the counters
        arm_mask(32'h8000000F);
        chk("clear_counters", {14'd0, armrdata[25:8]}, 32'd0);
        chk("clear_mask_kept", {24'd0, armrdata[7:0]}, 32'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unibus_irq_arbiter.md
Name: unibus_irq_arbiter

Overview:
- Shares the single Unibus interrupt path (BR4–BR7 / BG4–BG7 / SACK / INTR) among NDEV emulated devices, e.g. the line clock, DL11 serial lines and the RK disk.
- Each device presents a request, a vector and a fixed BR level. The arbiter picks one winner, runs the bus-request / grant / interrupt-transfer sequence, and pulses the winner's grant so it drops its request.
- The ARM side can mask devices and read status over the standard 2-register ARM interface.

Parameters:
- NDEV, 4: number of device request inputs, 1..8.
- LEVELS, 16'h00FF: 2 bits per device, device i level = LEVELS[2i+1:2i]; 0→BR4 … 3→BR7.
- TIMEOUT, 1000000: CLOCK cycles to wait for BG before abandoning the request.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- armwrite  in  1  ARM write strobe
- armraddr  in  1  ARM read register select
- armwaddr  in  1  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data
- dev_intreq  in  NDEV  per-device interrupt request, level-held until granted
- dev_irvec  in  8*NDEV  per-device vector bits [7:0], device i at [8i+7:8i]
- dev_intgnt  out  NDEV  one-cycle grant pulse to the winner
- init_in_h  in  1  Unibus INIT
- bus_bg_in_h  in  4  BG4..BG7 as [0..3]
- bus_ssyn_in_h  in  1  Unibus SSYN (CPU vector accept)
- bus_br_out_h  out  4  BR4..BR7 as [0..3]
- bus_sack_out_h  out  1  selection acknowledge
- bus_intr_out_h  out  1  INTR
- bus_d_out_h  out  16  vector driven onto data lines, else 0

Behaviour:
- Interface: one clock (CLOCK); reset (RESET) is synchronous and active-high.
- armrdata, register 0 = 32'h49410001: [31:16]='IA', [15:12]=0 (2 regs), [11:0]=version.
- armrdata, register 1 = { state[2:0], winner[2:0], timeouts[7:0], grants[9:0], mask[7:0] }.
- ARM write to reg 1: mask <= armwdata[7:0]. If armwdata[31]=1, clear grants and timeouts.
- Counters saturate at their max value.
- RESET: state=IDLE, mask=0, counters=0, all bus/dev outputs 0.
- init_in_h: state=IDLE, bus and dev outputs 0. mask and counters are kept.
- Eligible device: dev_intreq[i] & mask[i].
- Winner selection: highest level first; ties go to the lowest index.
- Winner and its level are latched on the IDLE→BRQ transition and frozen until the sequence ends. There is no preemption.
- State IDLE:
  - All outputs 0.
  - Any eligible device → latch winner; set bus_br_out_h[level] next cycle; go to BRQ.
- State BRQ (br held, timer counts):
  - bus_bg_in_h[level]=1 → br<=0, sack<=1, go to SACK.
  - Winner's request drops or its mask bit clears → br<=0, go to IDLE; no grant pulse.
  - Timer reaches TIMEOUT → br<=0, timeouts++, go to IDLE.
  - A BG on a different level is ignored.
- State SACK: wait for bus_bg_in_h[level]=0, then in the same cycle:
  - intr<=1
  - d<={8'b0, winner vector}
  - dev_intgnt[winner]<=1 for exactly 1 cycle
  - grants++
  - go to INTR
- State INTR: sack, intr and vector held until bus_ssyn_in_h=1; then intr<=0, sack<=0, d<=0, go to RELS.
- State RELS: wait for bus_ssyn_in_h=0, then go to IDLE. New arbitration starts no earlier than the next cycle.
- Latency: request to BR assert = 1 cycle. BG fall to INTR = 1 cycle.
- Only one bus_br_out_h bit is ever set. dev_intgnt is one-hot or zero.

Decomposition:
- Shared package irq_arb_pkg:
  - state encoding (IDLE=0, BRQ=1, SACK=2, INTR=3, RELS=4)
  - ID constant 32'h49410001
  - level-to-BR index helper
- Sub-module irq_prio_pick: combinational. Inputs are eligible vector and LEVELS; outputs are any, winner index [2:0] and level [1:0].

Test Plan:
- mask=0x0F; dev1 (BR6) requests, vector 0o100 → BR6 in 1 cycle; BG6 pulse → SACK; BG6 falls → INTR with d=0o000100 and 1-cycle dev_intgnt[1]; SSYN high → all dropped; grants=1.
- dev0 (BR4) and dev2 (BR6) request in the same cycle → dev2 served first, then dev0. With equal levels, the lower index wins.
- dev3 requests with mask bit 3 clear → no BR. Set the mask via ARM write → BR asserted next cycle.
- BRQ with BG never asserted, TIMEOUT=100 → BR dropped at cycle 100; timeouts=1; IDLE.
- init_in_h pulsed during INTR → next cycle all bus outputs 0, state IDLE, mask unchanged.
- dev_intreq drops during BRQ → BR cleared, no dev_intgnt pulse, grants unchanged.
